// File: rtl/decode_issue_stage.sv
// Registered decode-and-issue stage with a shifting write scoreboard that stalls fetch on RAW hazards.
// Optional feature: define DECODE_STALL_CNT_EN to add the saturating stall_cnt output.
module decode_issue_stage #(
    parameter int PIPE_DEPTH = 3,
    parameter int REG_AW     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [0:31] if_inst,
    input  logic        flush,
    output logic        id_ready,
    output logic        out_valid,
    output logic [0:4]  ID_rD,
    output logic [0:4]  ID_rA,
    output logic [0:4]  ID_rB,
    output logic [0:1]  ID_WW,
    output logic [0:2]  ID_ppp,
    output logic [0:15] imm_addr,
    output logic [0:5]  op_code,
    output logic        ID_wrEn,
    output logic        ID_memEn,
    output logic        ID_memwrEn,
    output logic        ID_decode_ctrl_bez,
    output logic        ID_decode_ctrl_bnez,
    output logic        rD_as_source
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [0:15] stall_cnt
`endif
);

    localparam logic [5:0] TYPE_RTYPE = 6'b101010;
    localparam logic [5:0] TYPE_VLD   = 6'b100000;
    localparam logic [5:0] TYPE_VSD   = 6'b100001;
    localparam logic [5:0] TYPE_VBEZ  = 6'b100010;
    localparam logic [5:0] TYPE_VBNEZ = 6'b100011;

    logic [5:0]  typ_s, op_s;
    logic [4:0]  rd_s, ra_s, rb_s;
    logic [2:0]  ppp_s;
    logic [1:0]  ww_s;
    logic [15:0] imm_s;

    assign typ_s = if_inst[0:5];
    assign rd_s  = if_inst[6:10];
    assign ra_s  = if_inst[11:15];
    assign rb_s  = if_inst[16:20];
    assign ppp_s = if_inst[21:23];
    assign ww_s  = if_inst[24:25];
    assign op_s  = if_inst[26:31];
    assign imm_s = if_inst[16:31];

    // Strobes ordered {wrEn, memEn, memwrEn, bez, bnez, rD_as_source}; src_v_s is {rD, rB, rA}.
    logic [5:0] strb_s;
    logic [2:0] src_v_s;
    logic       rtype_quiet_s;
    logic       ra_zero_s;
    logic       hit_s, hazard_s, issue_s;

    logic [PIPE_DEPTH-1:0] sb_v_q, sb_v_d;
    logic [REG_AW-1:0]     sb_d_q [PIPE_DEPTH];
    logic [REG_AW-1:0]     sb_d_d [PIPE_DEPTH];

    logic        out_valid_q, out_valid_d;
    logic [5:0]  strb_q, strb_d;
    logic [41:0] fields_q, fields_d;

    // Combinational strobe decode and source-operand selection.
    always_comb begin
        strb_s        = 6'b000000;
        src_v_s       = 3'b000;
        ra_zero_s     = (ra_s == 5'd0);
        rtype_quiet_s = (op_s inside {6'b000100, 6'b000101, 6'b001101,
                                      6'b010000, 6'b010001, 6'b010010}) && (rb_s != 5'd0);
        case (typ_s)
            TYPE_RTYPE: begin
                if (rtype_quiet_s) begin
                    strb_s  = 6'b000000;
                    src_v_s = 3'b011;
                end else begin
                    strb_s  = 6'b100001;
                    src_v_s = 3'b111;
                end
            end
            TYPE_VLD:   strb_s  = {1'b1, ra_zero_s, 4'b0000};
            TYPE_VSD: begin
                strb_s  = {1'b0, ra_zero_s, ra_zero_s, 3'b000};
                src_v_s = 3'b100;
            end
            TYPE_VBEZ: begin
                strb_s  = {3'b000, ra_zero_s, 2'b00};
                src_v_s = 3'b100;
            end
            TYPE_VBNEZ: begin
                strb_s  = {4'b0000, ra_zero_s, 1'b0};
                src_v_s = 3'b100;
            end
            default: begin
                strb_s  = 6'b000000;
                src_v_s = 3'b000;
            end
        endcase
    end

    // Hazard detection against every valid scoreboard entry; flush overrides the stall.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            hit_s = hit_s | (sb_v_q[i] &
                    ((src_v_s[0] & (ra_s[REG_AW-1:0] == sb_d_q[i])) |
                     (src_v_s[1] & (rb_s[REG_AW-1:0] == sb_d_q[i])) |
                     (src_v_s[2] & (rd_s[REG_AW-1:0] == sb_d_q[i]))));
        end
        hazard_s = if_valid & ~flush & hit_s;
        issue_s  = if_valid & ~flush & ~hit_s;
        id_ready = ~hazard_s;
    end

    // Next-state for scoreboard shift and output register.
    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (i == 0) begin
                sb_v_d[i] = issue_s & strb_s[5];
                sb_d_d[i] = rd_s[REG_AW-1:0];
            end else begin
                sb_v_d[i] = sb_v_q[i-1];
                sb_d_d[i] = sb_d_q[i-1];
            end
        end
        out_valid_d = issue_s;
        if (issue_s) begin
            strb_d   = strb_s;
            fields_d = {rd_s, ra_s, rb_s, ppp_s, ww_s, imm_s, op_s};
        end else begin
            strb_d   = 6'b000000;
            fields_d = fields_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_v_q      <= {PIPE_DEPTH{1'b0}};
            out_valid_q <= 1'b0;
            strb_q      <= 6'b000000;
            fields_q    <= 42'd0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_d_q[i] <= {REG_AW{1'b0}};
            end
        end else begin
            sb_v_q      <= sb_v_d;
            out_valid_q <= out_valid_d;
            strb_q      <= strb_d;
            fields_q    <= fields_d;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_d_q[i] <= sb_d_d[i];
            end
        end
    end

    assign out_valid           = out_valid_q;
    assign ID_wrEn             = strb_q[5];
    assign ID_memEn            = strb_q[4];
    assign ID_memwrEn          = strb_q[3];
    assign ID_decode_ctrl_bez  = strb_q[2];
    assign ID_decode_ctrl_bnez = strb_q[1];
    assign rD_as_source        = strb_q[0];
    assign ID_rD               = fields_q[41:37];
    assign ID_rA               = fields_q[36:32];
    assign ID_rB               = fields_q[31:27];
    assign ID_ppp              = fields_q[26:24];
    assign ID_WW               = fields_q[23:22];
    assign imm_addr            = fields_q[21:6];
    assign op_code             = fields_q[5:0];

`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of hazard cycles.
    always_comb begin
        if (hazard_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
